// File: rtl/dff_n_m_shift_if.sv
// Bus bundle for dff_n_m_shift: control strobes and load/shift/write data in,
// registered word window and status out.
interface dff_n_m_shift_if #(
    parameter int unsigned n = 32,
    parameter int unsigned m = 16
);
    logic                   clr_i;
    logic                   load_i;
    logic [n-1:0]           In_i [0:m-1];
    logic                   shift_i;
    logic [n-1:0]           sh_data_i;
    logic                   wr_en_i;
    logic [$clog2(m)-1:0]   wr_idx_i;
    logic [n-1:0]           wr_data_i;

    logic [n-1:0]           In_o [0:m-1];
    logic [n-1:0]           head_o;
    logic [$clog2(m+1)-1:0] count_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   err_o;

    modport master (
        output clr_i, load_i, In_i, shift_i, sh_data_i, wr_en_i, wr_idx_i, wr_data_i,
        input  In_o, head_o, count_o, full_o, empty_o, err_o
    );

    modport slave (
        input  clr_i, load_i, In_i, shift_i, sh_data_i, wr_en_i, wr_idx_i, wr_data_i,
        output In_o, head_o, count_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/dff_n_m_shift.sv
// Register window of m n-bit words: clear, parallel load, shift toward index 0
// and single-word write, one operation per cycle, with a sticky error flag.
module dff_n_m_shift #(
    parameter int unsigned   n     = 32,
    parameter int unsigned   m     = 16,
    parameter logic [n-1:0]  value = '0
) (
    input logic            clk_i,
    input logic            rst_i,
    dff_n_m_shift_if.slave bus
);
    localparam int unsigned CW = $clog2(m + 1);

    logic [n-1:0]  words_q [0:m-1];
    logic [n-1:0]  head_q;
    logic [CW-1:0] count_q;
    logic          err_q;
    logic          idx_ok;
    logic          count_sat;

    // Only reachable as false when m is not a power of two.
    assign idx_ok    = (32'(bus.wr_idx_i) < m);
    assign count_sat = (count_q == CW'(m));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < m; i++) words_q[i] <= value;
            head_q  <= value;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.clr_i) begin
            for (int unsigned i = 0; i < m; i++) words_q[i] <= value;
            head_q  <= value;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (bus.load_i) begin
            for (int unsigned i = 0; i < m; i++) words_q[i] <= bus.In_i[i];
            count_q <= CW'(m);
            if (bus.wr_en_i) err_q <= 1'b1;
        end else if (bus.shift_i) begin
            for (int unsigned i = 0; i < m - 1; i++) words_q[i] <= words_q[i+1];
            words_q[m-1] <= bus.sh_data_i;
            head_q       <= words_q[0];
            if (!count_sat) count_q <= count_q + CW'(1);
            if (bus.wr_en_i) err_q <= 1'b1;
        end else if (bus.wr_en_i) begin
            if (idx_ok) words_q[bus.wr_idx_i] <= bus.wr_data_i;
            else        err_q <= 1'b1;
        end
    end

    assign bus.In_o    = words_q;
    assign bus.head_o  = head_q;
    assign bus.count_o = count_q;
    assign bus.err_o   = err_q;
    assign bus.full_o  = count_sat;
    assign bus.empty_o = (count_q == '0);
endmodule

// File: tb/tb_dff_n_m_shift.sv
// Randomized bench for dff_n_m_shift: an m=4 and an m=3 build driven with the
// same stimulus and compared every cycle against a behavioural window model.
module tb_dff_n_m_shift;
    localparam logic [7:0] VAL = 8'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dff_n_m_shift_if #(.n(8), .m(4)) bus4 ();
    dff_n_m_shift_if #(.n(8), .m(3)) bus3 ();

    dff_n_m_shift #(.n(8), .m(4), .value(VAL)) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4.slave));
    dff_n_m_shift #(.n(8), .m(3), .value(VAL)) dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3.slave));

    // Outputs of both builds gathered into uniform arrays (index 0: m=4, 1: m=3).
    logic [7:0] o_w [2][4];
    logic [7:0] o_head [2];
    logic [2:0] o_cnt [2];
    logic       o_full [2], o_empty [2], o_err [2];

    always_comb begin
        for (int i = 0; i < 4; i++) o_w[0][i] = bus4.In_o[i];
        for (int i = 0; i < 3; i++) o_w[1][i] = bus3.In_o[i];
        o_w[1][3]  = '0;
        o_head[0]  = bus4.head_o;   o_head[1]  = bus3.head_o;
        o_cnt[0]   = bus4.count_o;  o_cnt[1]   = {1'b0, bus3.count_o};
        o_full[0]  = bus4.full_o;   o_full[1]  = bus3.full_o;
        o_empty[0] = bus4.empty_o;  o_empty[1] = bus3.empty_o;
        o_err[0]   = bus4.err_o;    o_err[1]   = bus3.err_o;
    end

    // Reference model: a window of sz words, an element counter and flags.
    int         msz [2] = '{4, 3};
    logic [7:0] mw [2][4];
    logic [7:0] mhead [2];
    int         mcnt [2];
    bit         merr [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) mw[d][i] = (i < msz[d]) ? VAL : 8'h00;
            mhead[d] = VAL;
            mcnt[d]  = 0;
            merr[d]  = 1'b0;
        end
    endtask

    task automatic model_op(input int d, input bit clr, input bit load, input logic [7:0] din [4],
                            input bit shift, input logic [7:0] sh, input bit wr, input int idx,
                            input logic [7:0] wd);
        int sz = msz[d];
        if (clr) begin
            for (int i = 0; i < sz; i++) mw[d][i] = VAL;
            mcnt[d] = 0; mhead[d] = VAL; merr[d] = 1'b0;
        end else if (load) begin
            for (int i = 0; i < sz; i++) mw[d][i] = din[i];
            mcnt[d] = sz;
            if (wr) merr[d] = 1'b1;
        end else if (shift) begin
            mhead[d] = mw[d][0];
            for (int i = 0; i < sz - 1; i++) mw[d][i] = mw[d][i+1];
            mw[d][sz-1] = sh;
            mcnt[d] = (mcnt[d] + 1 > sz) ? sz : mcnt[d] + 1;
            if (wr) merr[d] = 1'b1;
        end else if (wr) begin
            if (idx < sz) mw[d][idx] = wd;
            else          merr[d] = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < 2; d++) begin
            string pfx = $sformatf("%s/m%0d", tag, msz[d]);
            for (int i = 0; i < msz[d]; i++)
                check($sformatf("%s/w%0d", pfx, i), 32'(o_w[d][i]), 32'(mw[d][i]));
            check({pfx, "/head"},  32'(o_head[d]),  32'(mhead[d]));
            check({pfx, "/count"}, 32'(o_cnt[d]),   32'(mcnt[d]));
            check({pfx, "/full"},  32'(o_full[d]),  32'(mcnt[d] == msz[d]));
            check({pfx, "/empty"}, 32'(o_empty[d]), 32'(mcnt[d] == 0));
            check({pfx, "/err"},   32'(o_err[d]),   32'(merr[d]));
        end
    endtask

    task automatic drive(input bit clr, input bit load, input logic [7:0] din [4], input bit shift,
                         input logic [7:0] sh, input bit wr, input int idx, input logic [7:0] wd);
        bus4.clr_i = clr;     bus3.clr_i = clr;
        bus4.load_i = load;   bus3.load_i = load;
        for (int i = 0; i < 4; i++) bus4.In_i[i] = din[i];
        for (int i = 0; i < 3; i++) bus3.In_i[i] = din[i];
        bus4.shift_i = shift; bus3.shift_i = shift;
        bus4.sh_data_i = sh;  bus3.sh_data_i = sh;
        bus4.wr_en_i = wr;    bus3.wr_en_i = wr;
        bus4.wr_idx_i = 2'(idx);
        bus3.wr_idx_i = 2'(idx);
        bus4.wr_data_i = wd;  bus3.wr_data_i = wd;
    endtask

    // Apply one cycle of stimulus, advance the model, then sample mid-cycle.
    task automatic step(input string tag, input bit clr, input bit load, input logic [7:0] din [4],
                        input bit shift, input logic [7:0] sh, input bit wr, input int idx,
                        input logic [7:0] wd);
        drive(clr, load, din, shift, sh, wr, idx, wd);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model_op(d, clr, load, din, shift, sh, wr, idx, wd);
        check_all(tag);
    endtask

    // Reset dropped mid-cycle while a shift is pending; the shift must be lost.
    task automatic do_reset(input string tag);
        logic [7:0] z [4] = '{default: 8'h00};
        drive(1'b0, 1'b0, z, 1'b1, 8'hEE, 1'b1, 3, 8'h66);
        rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        rst = 1'b1;
        step({tag, "_first_op"}, 1'b0, 1'b0, z, 1'b1, 8'h11, 1'b0, 0, 8'h00);
    endtask

    initial begin
        logic [7:0] z [4] = '{default: 8'h00};
        logic [7:0] ld [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        logic [7:0] rd [4];

        drive(1'b0, 1'b0, z, 1'b0, 8'h00, 1'b0, 0, 8'h00);
        #2;
        do_reset("reset");
        step("clr", 1'b1, 1'b0, z, 1'b0, 8'h00, 1'b0, 0, 8'h00);
        check("reset_empty", 32'(bus4.empty_o), 32'd1);

        for (int k = 1; k <= 5; k++) begin
            step($sformatf("fill%0d", k), 1'b0, 1'b0, z, 1'b1, 8'(k), 1'b0, 0, 8'h00);
            if (k == 4) begin
                check("fill4_full", 32'(bus4.full_o), 32'd1);
                check("fill4_w0", 32'(bus4.In_o[0]), 32'h01);
                check("fill4_w3", 32'(bus4.In_o[3]), 32'h04);
            end
        end
        check("fill5_w0", 32'(bus4.In_o[0]), 32'h02);
        check("fill5_head", 32'(bus4.head_o), 32'h01);
        check("fill5_count", 32'(bus4.count_o), 32'd4);

        step("load", 1'b0, 1'b1, ld, 1'b0, 8'h00, 1'b0, 0, 8'h00);
        step("write2", 1'b0, 1'b0, z, 1'b0, 8'h00, 1'b1, 2, 8'h77);
        check("write2_w2", 32'(bus4.In_o[2]), 32'h77);
        check("write2_err", 32'(bus4.err_o), 32'd0);

        step("collide", 1'b0, 1'b0, z, 1'b1, 8'h99, 1'b1, 1, 8'hCC);
        check("collide_w3", 32'(bus4.In_o[3]), 32'h99);
        check("collide_err", 32'(bus4.err_o), 32'd1);
        for (int k = 0; k < 3; k++) step("idle_err", 1'b0, 1'b0, z, 1'b0, 8'h00, 1'b0, 0, 8'h00);
        check("sticky_err", 32'(bus4.err_o), 32'd1);

        step("prio", 1'b1, 1'b1, ld, 1'b1, 8'h33, 1'b0, 0, 8'h00);
        check("prio_count", 32'(bus4.count_o), 32'd0);
        check("prio_err", 32'(bus4.err_o), 32'd0);

        step("load2", 1'b0, 1'b1, ld, 1'b0, 8'h00, 1'b0, 0, 8'h00);
        step("badidx", 1'b0, 1'b0, z, 1'b0, 8'h00, 1'b1, 3, 8'h5A);
        check("badidx_m3_err", 32'(bus3.err_o), 32'd1);
        check("badidx_m4_err", 32'(bus4.err_o), 32'd0);

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_reset");
            end else begin
                step("rnd", $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, rd,
                     $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, 3)), 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
